// File: rtl/systemverilog_bus_mux.sv
// Bus-to-stream serializer: one-packet holding register feeding a byte shift register.
// Each accepted {adr, dat} write leaves as 8 bytes, least-significant byte first.
module systemverilog_bus_mux (
  input  logic        clk,
  input  logic        rst,
  input  logic        bus_vld,
  input  logic [31:0] bus_adr,
  input  logic [31:0] bus_dat,
  output logic        bus_rdy,
  output logic        str_vld,
  output logic [7:0]  str_bus,
  input  logic        str_rdy
);

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned PW = AW + DW;
  localparam int unsigned BW = 8;
  localparam int unsigned CW = 3;
  localparam logic [CW-1:0] LAST_BYTE = CW'(PW / BW - 1);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] hld_q, hld_d;
  logic          hld_vld_q, hld_vld_d;
  logic [PW-1:0] sft_q, sft_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          bus_xfer_c;
  logic          str_xfer_c;

  // All outputs come straight from flops.
  assign bus_rdy = ~hld_vld_q;
  assign str_vld = (state_q == SEND);
  assign str_bus = sft_q[BW-1:0];

  assign bus_xfer_c = bus_vld & ~hld_vld_q;
  assign str_xfer_c = (state_q == SEND) & str_rdy;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      hld_q     <= '0;
      hld_vld_q <= 1'b0;
      sft_q     <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      hld_q     <= hld_d;
      hld_vld_q <= hld_vld_d;
      sft_q     <= sft_d;
      cnt_q     <= cnt_d;
    end
  end

  // A bus load needs hld_vld=0 and a move needs hld_vld=1, so they never collide.
  always_comb begin
    state_d   = state_q;
    hld_d     = hld_q;
    hld_vld_d = hld_vld_q;
    sft_d     = sft_q;
    cnt_d     = cnt_q;

    if (bus_xfer_c) begin
      hld_d     = {bus_adr, bus_dat};
      hld_vld_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (hld_vld_q) begin
          sft_d     = hld_q;
          cnt_d     = '0;
          hld_vld_d = 1'b0;
          state_d   = SEND;
        end
      end
      SEND: begin
        if (str_xfer_c) begin
          if (cnt_q != LAST_BYTE) begin
            sft_d = sft_q >> BW;
            cnt_d = cnt_q + CW'(1);
          end else if (hld_vld_q) begin
            sft_d     = hld_q;
            cnt_d     = '0;
            hld_vld_d = 1'b0;
          end else begin
            sft_d   = sft_q >> BW;
            cnt_d   = '0;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_systemverilog_bus_mux.sv
// Directed bench for systemverilog_bus_mux: vector table plus hand-written
// back-to-back, backpressure, hold-full, reset and demux-loopback sequences.
module tb_systemverilog_bus_mux;

  logic        clk;
  logic        rst;
  logic        bus_vld;
  logic [31:0] bus_adr;
  logic [31:0] bus_dat;
  logic        bus_rdy;
  logic        str_vld;
  logic [7:0]  str_bus;
  logic        str_rdy;

  systemverilog_bus_mux dut (
    .clk     (clk),
    .rst     (rst),
    .bus_vld (bus_vld),
    .bus_adr (bus_adr),
    .bus_dat (bus_dat),
    .bus_rdy (bus_rdy),
    .str_vld (str_vld),
    .str_bus (str_bus),
    .str_rdy (str_rdy)
  );

  typedef struct {
    logic [31:0] adr;
    logic [31:0] dat;
    logic [63:0] exp;   // expected stream, byte 0 in the top byte
  } vec_t;

  vec_t        vecs[4];
  int          nchecks = 0;
  int          nerr = 0;
  int          cyc = 0;
  int          rdy_mode = 0;
  int          ph = 0;
  logic [7:0]  bq[$];
  int          sq[$];
  logic [7:0]  eq[$];
  logic        prev_stall = 1'b0;
  logic [7:0]  prev_byte = 8'h00;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // str_rdy: 0 = always 1, 1 = pattern 1,0,0 repeating, 2 = always 0
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       str_rdy = 1'b1;
      1:       str_rdy = (ph % 3 == 0);
      default: str_rdy = 1'b0;
    endcase
    ph = ph + 1;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Stream monitor: records accepted bytes and checks stability under stall.
  always @(negedge clk) begin
    if (!rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_vld_stable", 64'(str_vld), 64'd1);
        chk("stall_byte_stable", 64'(str_bus), 64'(prev_byte));
      end
      if (str_vld && str_rdy) begin
        bq.push_back(str_bus);
        sq.push_back(cyc + 1);
      end
      prev_stall = str_vld && !str_rdy;
      prev_byte  = str_bus;
    end
  end

  task automatic clear_q();
    bq.delete();
    sq.delete();
    eq.delete();
  endtask

  task automatic add_vec(input vec_t v);
    for (int k = 0; k < 8; k++) eq.push_back(v.exp[63-8*k -: 8]);
  endtask

  task automatic wait_rdy(output int acc);
    int n;
    n = 0;
    @(negedge clk);
    while (!bus_rdy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!bus_rdy) begin
      chk("bus_rdy_timeout", 64'd0, 64'd1);
      acc = -1;
    end else begin
      acc = cyc + 1;
    end
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] d, output int acc);
    @(posedge clk);
    #1;
    bus_vld = 1'b1;
    bus_adr = a;
    bus_dat = d;
    wait_rdy(acc);
    @(posedge clk);
    #1;
    bus_vld = 1'b0;
    bus_adr = $urandom;
    bus_dat = $urandom;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_stream(input string name, input int acc, input logic contiguous);
    int gaps;
    chk({name, "_count"}, 64'(bq.size()), 64'(eq.size()));
    for (int k = 0; k < eq.size() && k < bq.size(); k++)
      chk($sformatf("%s_byte%0d", name, k), 64'(bq[k]), 64'(eq[k]));
    if (acc >= 0 && sq.size() > 0)
      chk({name, "_latency"}, 64'(sq[0] - acc), 64'd2);
    if (contiguous) begin
      gaps = 0;
      for (int k = 1; k < sq.size(); k++) if (sq[k] != sq[k-1] + 1) gaps++;
      chk({name, "_contiguous"}, 64'(gaps), 64'd0);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int          acc, acc2, zeros;
    logic [31:0] la[6];
    logic [31:0] ld[6];
    logic [31:0] ra, rd;

    vecs[0] = '{adr: 32'h12345678, dat: 32'hCAFEF00D, exp: 64'h0DF0FECA_78563412};
    vecs[1] = '{adr: 32'h00000000, dat: 32'hFFFFFFFF, exp: 64'hFFFFFFFF_00000000};
    vecs[2] = '{adr: 32'hA5A55A5A, dat: 32'h01020304, exp: 64'h04030201_5A5AA5A5};
    vecs[3] = '{adr: 32'h80000001, dat: 32'h7F00FF10, exp: 64'h10FF007F_01000080};

    rst = 1'b0;
    bus_vld = 1'b0;
    bus_adr = 32'h0;
    bus_dat = 32'h0;
    str_rdy = 1'b0;
    #13;
    chk("reset_bus_rdy", 64'(bus_rdy), 64'd1);
    chk("reset_str_vld", 64'(str_vld), 64'd0);
    chk("reset_str_bus", 64'(str_bus), 64'h00);
    #10;
    rst = 1'b1;
    wait_cycles(3);

    // Single transactions from the table, str_rdy held 1.
    for (int v = 0; v < 4; v++) begin
      clear_q();
      add_vec(vecs[v]);
      send(vecs[v].adr, vecs[v].dat, acc);
      @(negedge clk);
      chk($sformatf("v%0d_rdy_after_xfer", v), 64'(bus_rdy), 64'd0);
      chk($sformatf("v%0d_vld_after_xfer", v), 64'(str_vld), 64'd0);
      @(negedge clk);
      chk($sformatf("v%0d_rdy_after_move", v), 64'(bus_rdy), 64'd1);
      chk($sformatf("v%0d_vld_byte0", v), 64'(str_vld), 64'd1);
      wait_cycles(12);
      check_stream($sformatf("v%0d", v), acc, 1'b1);
      chk($sformatf("v%0d_idle_after", v), 64'(str_vld), 64'd0);
    end

    // Back-to-back with bus_vld held high.
    clear_q();
    add_vec(vecs[0]);
    add_vec(vecs[2]);
    @(posedge clk);
    #1;
    bus_vld = 1'b1;
    bus_adr = vecs[0].adr;
    bus_dat = vecs[0].dat;
    wait_rdy(acc);
    @(posedge clk);
    #1;
    bus_adr = vecs[2].adr;
    bus_dat = vecs[2].dat;
    wait_rdy(acc2);
    @(posedge clk);
    #1;
    bus_vld = 1'b0;
    chk("b2b_second_accept", 64'(acc2 - acc), 64'd2);
    zeros = 0;
    repeat (7) begin
      @(negedge clk);
      if (!bus_rdy) zeros++;
    end
    chk("b2b_rdy_low_while_held", 64'(zeros), 64'd7);
    @(negedge clk);
    chk("b2b_rdy_after_move", 64'(bus_rdy), 64'd1);
    wait_cycles(12);
    check_stream("b2b", acc, 1'b1);

    // Backpressure with str_rdy pattern 1,0,0.
    clear_q();
    add_vec(vecs[3]);
    rdy_mode = 1;
    send(vecs[3].adr, vecs[3].dat, acc);
    wait_cycles(40);
    check_stream("bp", -1, 1'b0);
    rdy_mode = 0;
    wait_cycles(2);

    // Hold full: two accepted, stream stalled, third not acknowledged.
    clear_q();
    add_vec(vecs[1]);
    add_vec(vecs[3]);
    rdy_mode = 2;
    wait_cycles(2);
    send(vecs[1].adr, vecs[1].dat, acc);
    send(vecs[3].adr, vecs[3].dat, acc2);
    @(posedge clk);
    #1;
    bus_vld = 1'b1;
    bus_adr = 32'hDEADBEEF;
    bus_dat = 32'h55AA55AA;
    zeros = 0;
    repeat (20) begin
      @(negedge clk);
      if (!bus_rdy) zeros++;
    end
    chk("full_rdy_low", 64'(zeros), 64'd20);
    chk("full_no_bytes", 64'(bq.size()), 64'd0);
    @(posedge clk);
    #1;
    bus_vld = 1'b0;
    rdy_mode = 0;
    wait_cycles(30);
    check_stream("full", -1, 1'b1);

    // Reset after byte 3 with a second transaction held.
    clear_q();
    send(vecs[0].adr, vecs[0].dat, acc);
    send(vecs[2].adr, vecs[2].dat, acc2);
    for (int n = 0; n < 50 && bq.size() < 4; n++) begin
      @(posedge clk);
      #1;
    end
    chk("rst_bytes_before", 64'(bq.size()), 64'd4);
    #2;
    rst = 1'b0;
    #1;
    chk("rst_async_str_vld", 64'(str_vld), 64'd0);
    chk("rst_async_str_bus", 64'(str_bus), 64'h00);
    chk("rst_async_bus_rdy", 64'(bus_rdy), 64'd1);
    @(posedge clk);
    @(posedge clk);
    #3;
    rst = 1'b1;
    clear_q();
    for (int k = 0; k < 8; k++) eq.push_back(k == 0 ? 8'hFF : 8'h00);
    send(32'h0, 32'h000000FF, acc);
    wait_cycles(14);
    check_stream("post_rst", acc, 1'b1);
    chk("post_rst_idle", 64'(str_vld), 64'd0);

    // Loopback through a demux model under backpressure.
    clear_q();
    rdy_mode = 1;
    for (int p = 0; p < 6; p++) begin
      la[p] = $urandom;
      ld[p] = $urandom;
      send(la[p], ld[p], acc);
    end
    for (int n = 0; n < 600 && bq.size() < 48; n++) @(posedge clk);
    #1;
    chk("loop_count", 64'(bq.size()), 64'd48);
    for (int p = 0; p < 6 && bq.size() >= 48; p++) begin
      rd = {bq[8*p+3], bq[8*p+2], bq[8*p+1], bq[8*p+0]};
      ra = {bq[8*p+7], bq[8*p+6], bq[8*p+5], bq[8*p+4]};
      chk($sformatf("loop%0d_adr", p), 64'(ra), 64'(la[p]));
      chk($sformatf("loop%0d_dat", p), 64'(rd), 64'(ld[p]));
    end
    rdy_mode = 0;
    wait_cycles(2);

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end

endmodule

// File: doc/systemverilog_bus_mux.md
# systemverilog_bus_mux

Bus-to-stream serializer that sits directly upstream of the bus demux stage. It accepts single 32-bit address + 32-bit data write transactions on a valid/ready bus slave port. Each transaction becomes an 8-byte packet on a valid/ready byte stream, in the byte order the demux reassembles. It has a one-packet holding register in front of a shift-register serializer, so the bus side can post the next transaction while the current packet drains.

## Interface
- Parameters: none.
- `clk` input 1: system clock; all state changes on rising edge.
- `rst` input 1: reset, asynchronous, active-low. Asserted when 0; all flops reset immediately on assertion.
- `bus_vld` input 1: bus valid (chip select).
- `bus_adr` input 32: bus address.
- `bus_dat` input 32: bus data.
- `bus_rdy` output 1: ready (acknowledge). A bus transfer happens on a cycle with `bus_vld & bus_rdy`.
- `str_vld` output 1: stream byte valid.
- `str_bus` output 8: stream byte.
- `str_rdy` input 1: stream ready. A byte transfer happens on a cycle with `str_vld & str_rdy`.

## Operation
- Packet format: 64-bit word `{adr[31:0], dat[31:0]}`, sent least-significant byte first.
  - Byte 0 is `dat[7:0]`.
  - Byte 3 is `dat[31:24]`.
  - Byte 4 is `adr[7:0]`.
  - Byte 7 is `adr[31:24]`.
- Holding stage:
  - State: 64-bit register `hld` and flag `hld_vld`.
  - `bus_rdy = ~hld_vld`, driven directly from the flop with no combinational path from inputs.
  - A bus transfer loads `hld <= {bus_adr, bus_dat}` and sets `hld_vld`.
- Serializer stage:
  - State: 64-bit shift register `sft`, 3-bit byte counter `cnt`, and the `str_vld` flop.
  - `str_bus = sft[7:0]`.
- Serializer states:
  - IDLE: `str_vld=0`.
  - SEND: `str_vld=1`.
- IDLE → SEND when `hld_vld=1`:
  - `sft <= hld`, `cnt <= 0`.
  - Clear `hld_vld`.
- SEND, byte transfer with `cnt != 7`:
  - `sft <= sft >> 8` with zero fill.
  - `cnt <= cnt + 1`.
- SEND, byte transfer with `cnt == 7` (last byte):
  - If `hld_vld=1`: reload `sft <= hld`, `cnt <= 0`, clear `hld_vld`, stay in SEND. There is no idle bubble.
  - Otherwise go to IDLE and set `cnt <= 0`.
- SEND with `str_rdy=0`: `sft`, `cnt` and `str_vld` hold. `str_bus` is stable until accepted.
- Simultaneous events:
  - A bus transfer and a `hld`→`sft` move cannot collide, because a bus transfer needs `hld_vld=0` and a move needs `hld_vld=1`.
  - `hld_vld` is set only by a bus transfer and cleared only by a move.
- `cnt` is a 3-bit counter. It wraps 7→0 only through the last-byte rule above and never free-runs.
- Reset values, applied while `rst=0`:
  - `hld_vld=0`, so `bus_rdy=1`.
  - `str_vld=0`, `str_bus=8'h00`.
  - `sft=0`, `hld=0`, `cnt=0`.
- Reset mid-packet discards the partial packet and any held transaction. The first packet after reset release starts at byte 0.

## Timing
- Bus transfer at edge N gives `hld_vld=1` and `bus_rdy=0` after edge N.
- With the serializer IDLE:
  - `str_vld=1` with byte 0 after edge N+1.
  - `bus_rdy=1` again after edge N+1.
  - Latency from bus acceptance to first byte on the stream is 2 cycles.
- With `str_rdy` held 1:
  - One byte per cycle.
  - Back-to-back packets are contiguous, 8 bytes per 8 cycles.
  - Sustained bus throughput is one transaction per 8 cycles.
- Held transaction:
  - `bus_rdy` stays 0 from its bus transfer until the cycle after it moves into `sft`.
  - At most 2 transactions are in flight: one in `sft`, one in `hld`.
- `bus_adr` and `bus_dat` are sampled only on the transfer edge.
- `str_vld` never drops while a packet is incomplete, regardless of `str_rdy`.

## Test plan
- Single transaction, `adr=32'h12345678`, `dat=32'hCAFEF00D`, `str_rdy=1`:
  - `str_bus` carries 0D, F0, FE, CA, 78, 56, 34, 12 on 8 consecutive cycles starting 2 cycles after the bus transfer.
  - `str_vld` is then 0.
- Two transactions with `bus_vld` held high:
  - The second is accepted the cycle after the first moves into `sft`, then `bus_rdy` stays 0.
  - The 16 bytes come out with no gap between byte 7 and the next byte 0.
- Backpressure, `str_rdy` toggling 1,0,0,1,…:
  - `str_bus` and `str_vld` are stable on every `str_rdy=0` cycle.
  - Byte order is unchanged and exactly 8 bytes are transferred.
- Hold full, `str_rdy=0` for 20 cycles after 2 accepted transactions:
  - `bus_rdy=0` throughout and a third `bus_vld` is not acknowledged.
  - Once `str_rdy=1`, all 16 bytes arrive in order.
- Reset asserted after byte 3 of a packet, with a second transaction held:
  - `str_vld=0`, `str_bus=8'h00` and `bus_rdy=1` immediately, without waiting for a clock edge.
  - After release, a new transaction `adr=32'h0`, `dat=32'h000000FF` yields FF, 00, 00, 00, 00, 00, 00, 00.
- Loopback into the demux stage:
  - Random `adr`/`dat` pairs driven in.
  - The demux `bus_adr` and `bus_dat` equal the pairs driven into this block.
